// File: rtl/fir_interp_pkg.sv
// fir_interp_pkg: shared widths, FSM states, coefficient ROM and round/saturate helper for the pre-CIC interpolator
package fir_interp_pkg;
    localparam int IBITS  = 16;
    localparam int OBITS  = 20;
    localparam int CBITS  = 18;
    localparam int L      = 4;
    localparam int NTAP   = 8;
    localparam int PW     = $clog2(L);
    localparam int KW     = $clog2(NTAP);
    localparam int AWIDTH = IBITS + CBITS + KW;
    localparam int SH     = IBITS + CBITS - 1 - OBITS;
    localparam logic signed [AWIDTH-1:0] RND_HALF = AWIDTH'(1) <<< (SH - 1);
    localparam logic signed [AWIDTH-1:0] SAT_MAX  = AWIDTH'(2 ** (OBITS - 1) - 1);
    localparam logic signed [AWIDTH-1:0] SAT_MIN  = AWIDTH'(-(2 ** (OBITS - 1)));

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    // Index is {tap k, phase p}, i.e. n = p + L*k. Tap signs depend only on k (ends negative),
    // and the centre pair is skewed per phase so every phase sums to 2^(CBITS-1).
    function automatic logic signed [CBITS-1:0] coef(input logic [PW+KW-1:0] n);
        int k;
        int p;
        k = int'(n[PW+KW-1:PW]);
        p = int'(n[PW-1:0]);
        return (k == 0 || k == 7) ? CBITS'(-2048) :
               (k == 1 || k == 6) ? CBITS'(6144) :
               (k == 2 || k == 5) ? CBITS'(16384) :
               (k == 3)           ? CBITS'(45056 + 4096 * p) :
                                    CBITS'(45056 - 4096 * p);
    endfunction

    // Round half-up, arithmetic shift by SH, clamp to the signed OBITS range.
    function automatic logic signed [OBITS-1:0] sat_round(input logic signed [AWIDTH-1:0] a);
        logic signed [AWIDTH-1:0] r;
        r = (a + RND_HALF) >>> SH;
        return (r > SAT_MAX) ? SAT_MAX[OBITS-1:0] :
               (r < SAT_MIN) ? SAT_MIN[OBITS-1:0] : r[OBITS-1:0];
    endfunction
endpackage

// File: rtl/fir_interp_mac.sv
// fir_interp_mac: one lane of the interpolator - sample delay line, serial multiply-accumulate, round/saturate output register
// Ports:
//   i_clock, i_reset : clock, async active-high reset
//   i_shift, i_x     : push i_x into the delay line
//   i_clr            : clear accumulator (start of a computation)
//   i_acc, i_tap     : accumulate d[i_tap] * i_coef
//   i_coef           : coefficient for the current tap
//   i_load           : register sat_round(acc) into o_y
//   o_y              : output sample, held between loads
module fir_interp_mac
    import fir_interp_pkg::*;
(
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_shift,
    input  logic signed [IBITS-1:0] i_x,
    input  logic                    i_clr,
    input  logic                    i_acc,
    input  logic [KW-1:0]           i_tap,
    input  logic signed [CBITS-1:0] i_coef,
    input  logic                    i_load,
    output logic signed [OBITS-1:0] o_y
);
    logic signed [IBITS-1:0]       r_d [NTAP];
    logic signed [AWIDTH-1:0]      r_acc;
    logic signed [IBITS+CBITS-1:0] w_prod;

    assign w_prod = r_d[i_tap] * i_coef;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int j = 0; j < NTAP; j++) r_d[j] <= '0;
            r_acc <= '0;
            o_y   <= '0;
        end else begin
            if (i_shift) begin
                r_d[0] <= i_x;
                for (int j = 1; j < NTAP; j++) r_d[j] <= r_d[j-1];
            end
            if (i_clr) r_acc <= '0;
            else if (i_acc) r_acc <= r_acc + AWIDTH'(w_prod);
            if (i_load) o_y <= sat_round(r_acc);
        end
    end
endmodule

// File: rtl/fir_interp_pre_cic.sv
// fir_interp_pre_cic: xL polyphase FIR interpolator feeding the CIC; one serial-MAC output per out_req pulse
// Ports:
//   i_clock, i_reset      : clock, async active-high reset
//   i_x_real, i_x_imag    : input IQ sample, taken when a phase-0 computation starts
//   o_in_req              : one-cycle pulse after a sample was consumed
//   i_out_req             : one-cycle request for the next output
//   o_y_real, o_y_imag    : output IQ sample, updated at the end of ROUND
//   o_busy                : computation in progress
//   o_overrun             : sticky, a request was dropped because one was already pending
module fir_interp_pre_cic
    import fir_interp_pkg::*;
(
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic signed [IBITS-1:0] i_x_real,
    input  logic signed [IBITS-1:0] i_x_imag,
    output logic                    o_in_req,
    input  logic                    i_out_req,
    output logic signed [OBITS-1:0] o_y_real,
    output logic signed [OBITS-1:0] o_y_imag,
    output logic                    o_busy,
    output logic                    o_overrun
);
    state_t              r_state;
    logic [PW-1:0]       r_phase;
    logic [KW-1:0]       r_tap;
    logic                r_pending;
    logic                w_start;
    logic                w_shift;
    logic signed [CBITS-1:0] w_coef;

    assign w_start = (r_state == IDLE) && (i_out_req || r_pending);
    assign w_shift = w_start && (r_phase == '0);
    assign w_coef  = coef({r_tap, r_phase});

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_tap     <= '0;
            r_pending <= 1'b0;
            o_overrun <= 1'b0;
            o_in_req  <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_in_req <= w_shift;
            case (r_state)
                IDLE: begin
                    // With both a pending and a fresh request, one is served and the other stays queued.
                    r_pending <= r_pending && i_out_req;
                    if (w_start) begin
                        r_state <= MAC;
                        r_tap   <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                MAC: begin
                    r_tap <= r_tap + 1'b1;
                    if (r_tap == KW'(NTAP - 1)) r_state <= ROUND;
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                    r_phase <= (r_phase == PW'(L - 1)) ? '0 : r_phase + 1'b1;
                end
            endcase
            if (r_state != IDLE && i_out_req) begin
                if (r_pending) o_overrun <= 1'b1;
                else r_pending <= 1'b1;
            end
        end
    end

    fir_interp_mac u_mac_real (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_shift (w_shift),
        .i_x     (i_x_real),
        .i_clr   (w_start),
        .i_acc   (r_state == MAC),
        .i_tap   (r_tap),
        .i_coef  (w_coef),
        .i_load  (r_state == ROUND),
        .o_y     (o_y_real)
    );

    fir_interp_mac u_mac_imag (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_shift (w_shift),
        .i_x     (i_x_imag),
        .i_clr   (w_start),
        .i_acc   (r_state == MAC),
        .i_tap   (r_tap),
        .i_coef  (w_coef),
        .i_load  (r_state == ROUND),
        .o_y     (o_y_imag)
    );
endmodule

// File: tb/tb_fir_interp_pre_cic.sv
// tb_fir_interp_pre_cic: directed self-checking bench for the pre-CIC polyphase interpolator
module tb_fir_interp_pre_cic;
    logic               clk;
    logic               rst;
    logic signed [15:0] x_real;
    logic signed [15:0] x_imag;
    logic               in_req;
    logic               out_req;
    logic signed [19:0] y_real;
    logic signed [19:0] y_imag;
    logic               busy;
    logic               overrun;
    int                 checks;
    int                 errors;

    // Impulse response: 16384 * C[n] / 8192 = 2*C[n], n = phase + 4*tap.
    localparam int IMP [32] = '{
        -4096, -4096, -4096, -4096,
        12288, 12288, 12288, 12288,
        32768, 32768, 32768, 32768,
        90112, 98304, 106496, 114688,
        90112, 81920, 73728, 65536,
        32768, 32768, 32768, 32768,
        12288, 12288, 12288, 12288,
        -4096, -4096, -4096, -4096};

    fir_interp_pre_cic dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_x_real  (x_real),
        .i_x_imag  (x_imag),
        .o_in_req  (in_req),
        .i_out_req (out_req),
        .o_y_real  (y_real),
        .o_y_imag  (y_imag),
        .o_busy    (busy),
        .o_overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Request is sampled on the first edge inside; returns 1 time unit after that edge (E0+1).
    task automatic req();
        out_req = 1'b1;
        step(1);
        out_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++;
        if (y_real !== 20'sd0 || y_imag !== 20'sd0 || in_req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state y=%0d/%0d in_req=%b busy=%b overrun=%b expected all 0", y_real, y_imag, in_req, busy, overrun);
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_impulse();
        do_reset();
        for (int n = 0; n < 32; n++) begin
            x_real = (n == 0) ? 16'sd16384 : 16'sd0;
            x_imag = 16'sd0;
            req();
            if (n == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL impulse_busy got %b expected 1", busy);
                end
                step(8);
                checks++;
                if (y_real !== 20'sd0) begin
                    errors++;
                    $display("FAIL latency_early y_real=%0d expected 0", y_real);
                end
                step(1);
            end else step(9);
            checks++;
            if (y_real !== 20'(IMP[n]) || y_imag !== 20'sd0) begin
                errors++;
                $display("FAIL impulse n=%0d y=%0d/%0d expected %0d/0", n, y_real, y_imag, IMP[n]);
            end
        end
    endtask

    task automatic test_dc();
        do_reset();
        x_real = 16'sd32767;
        x_imag = -16'sd32768;
        for (int n = 0; n < 36; n++) begin
            req();
            step(9);
            if (n >= 32) begin
                checks++;
                if (y_real !== 20'sd524272 || y_imag !== -20'sd524288) begin
                    errors++;
                    $display("FAIL dc n=%0d y=%0d/%0d expected 524272/-524288", n, y_real, y_imag);
                end
            end
        end
    endtask

    task automatic test_in_req_rate();
        int total;
        int cnt;
        total = 0;
        do_reset();
        x_real = 16'sd0;
        x_imag = 16'sd0;
        for (int r = 0; r < 40; r++) begin
            req();
            checks++;
            if (in_req !== (r % 4 == 0)) begin
                errors++;
                $display("FAIL in_req_edge req=%0d got %b expected %b", r, in_req, r % 4 == 0);
            end
            cnt = in_req ? 1 : 0;
            for (int c = 0; c < 319; c++) begin
                step(1);
                if (in_req) cnt++;
            end
            checks++;
            if (cnt != ((r % 4 == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL in_req_count req=%0d got %0d expected %0d", r, cnt, (r % 4 == 0) ? 1 : 0);
            end
            total += cnt;
        end
        checks++;
        if (total != 10) begin
            errors++;
            $display("FAIL in_req_total got %0d expected 10", total);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        x_real = 16'sd0;
        x_imag = 16'sd0;
        for (int n = 0; n < 3; n++) begin
            req();
            step(9);
        end
        x_real = 16'sd16384;
        req();
        step(2);
        req();
        step(5);
        checks++;
        if (y_real !== 20'sd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first y_real=%0d busy=%b expected 0/1", y_real, busy);
        end
        step(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap busy=%b expected 0", busy);
        end
        step(1);
        checks++;
        if (busy !== 1'b1 || in_req !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_start busy=%b in_req=%b expected 1/1", busy, in_req);
        end
        step(8);
        checks++;
        if (y_real !== 20'sd0) begin
            errors++;
            $display("FAIL b2b_second_early y_real=%0d expected 0", y_real);
        end
        step(1);
        checks++;
        if (y_real !== -20'sd4096 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second y_real=%0d overrun=%b expected -4096/0", y_real, overrun);
        end
        req();
        step(2);
        req();
        step(1);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early got %b expected 0", overrun);
        end
        req();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got %b expected 1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        step(10);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1 || y_real !== -20'sd4096) begin
            errors++;
            $display("FAIL overrun_sticky overrun=%b busy=%b y_real=%0d expected 1/1/-4096", overrun, busy, y_real);
        end
        rst = 1'b1;
        step(1);
        checks++;
        if (y_real !== 20'sd0 || y_imag !== 20'sd0 || in_req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid y=%0d/%0d in_req=%b busy=%b overrun=%b expected all 0", y_real, y_imag, in_req, busy, overrun);
        end
        step(2);
        checks++;
        if (in_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold in_req=%b busy=%b expected 0/0", in_req, busy);
        end
        rst = 1'b0;
        step(1);
        x_real = 16'sd16384;
        x_imag = 16'sd0;
        req();
        checks++;
        if (in_req !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_req got %b expected 1", in_req);
        end
        step(9);
        checks++;
        if (y_real !== -20'sd4096) begin
            errors++;
            $display("FAIL post_reset_phase0 y_real=%0d expected -4096", y_real);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int r = 0; r < 32; r++) begin
            x_real = (r / 4 == 0 || r / 4 == 7) ? -16'sd32767 : 16'sd32767;
            x_imag = -x_real;
            req();
            step(9);
            if (r >= 28) begin
                checks++;
                if (y_real !== 20'sd524287 || y_imag !== -20'sd524288) begin
                    errors++;
                    $display("FAIL saturation r=%0d y=%0d/%0d expected 524287/-524288", r, y_real, y_imag);
                end
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        x_real = 16'sd0;
        x_imag = 16'sd0;
        out_req = 1'b0;
        checks = 0;
        errors = 0;
        test_reset();
        test_impulse();
        test_dc();
        test_in_req_rate();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
